// File: rtl/lvds_link_ctrl.sv
// lvds_link_ctrl: LVDS lane-pair bring-up (serdes reset, align wait, training echo)
// followed by round-robin arbitration of two requesters onto the TX enqueue port.
module lvds_link_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                RST_HOLD   = 16,
    parameter int                TIMEOUT    = 4096,
    parameter int                MAX_RETRY  = 3,
    parameter logic [DATA_W-1:0] TRAIN_WORD = 32'hA5C3_5A3C
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              tx_align_done,
    input  logic              rx_align_done,
    output logic              lvds_reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] enq_tx,
    output logic              EN_enq_tx,
    input  logic              RDY_enq_tx,
    input  logic [DATA_W-1:0] deq_rx,
    input  logic              RDY_deq_rx,
    output logic              EN_deq_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              link_up,
    output logic              link_fail,
    output logic [1:0]        retry_cnt
);
    localparam int CNT_MAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

    typedef enum logic [2:0] {RST_LVDS, WAIT_ALIGN, TRAIN_TX, TRAIN_RX, UP, FAIL} state_t;

    state_t          r_state, w_next, w_fail_dst;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_tx_sync, r_rx_sync;
    logic            r_prio;
    logic            r_lvds_reset_n, r_link_up, r_link_fail;
    logic [1:0]      r_retry_cnt, w_retry_nxt;
    logic            w_aligned, w_timeout, w_up, w_tx_fire, w_rx_match, w_attempt_fail;

    assign w_aligned  = r_tx_sync[1] & r_rx_sync[1];
    assign w_timeout  = (r_cnt == TO_LAST);
    assign w_up       = (r_state == UP);
    assign w_tx_fire  = (r_state == TRAIN_TX) & RDY_enq_tx;
    assign w_rx_match = (r_state == TRAIN_RX) & RDY_deq_rx & (deq_rx == TRAIN_WORD);
    assign w_fail_dst = (r_retry_cnt < RETRY_LIM) ? RST_LVDS : FAIL;

    // Progress in a phase always beats a timeout landing in the same cycle
    assign w_attempt_fail = w_timeout & (((r_state == WAIT_ALIGN) & ~w_aligned) |
                                         ((r_state == TRAIN_TX)   & ~w_tx_fire) |
                                         ((r_state == TRAIN_RX)   & ~w_rx_match));

    assign w_retry_nxt = (w_next == UP) ? 2'd0 :
                         (w_attempt_fail && r_retry_cnt < RETRY_LIM) ? r_retry_cnt + 2'd1 :
                         r_retry_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_sync <= '0;
            r_rx_sync <= '0;
        end else begin
            r_tx_sync <= {r_tx_sync[0], tx_align_done};
            r_rx_sync <= {r_rx_sync[0], rx_align_done};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= RST_LVDS;
            r_cnt          <= '0;
            r_lvds_reset_n <= 1'b0;
            r_link_up      <= 1'b0;
            r_link_fail    <= 1'b0;
            r_retry_cnt    <= '0;
            r_prio         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= (w_next != r_state) ? '0 :
                              (r_state == UP || r_state == FAIL) ? r_cnt : r_cnt + 1'b1;
            // Status flops are loaded from the next state so they line up with r_state
            r_lvds_reset_n <= (w_next != RST_LVDS);
            r_link_up      <= (w_next == UP);
            r_link_fail    <= (w_next == FAIL);
            r_retry_cnt    <= w_retry_nxt;
            r_prio         <= req0_ready ? 1'b1 : req1_ready ? 1'b0 : r_prio;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_LVDS:   w_next = (r_cnt == HOLD_LAST) ? WAIT_ALIGN : RST_LVDS;
            WAIT_ALIGN: w_next = w_aligned ? TRAIN_TX : w_timeout ? w_fail_dst : WAIT_ALIGN;
            TRAIN_TX:   w_next = w_tx_fire ? TRAIN_RX : w_timeout ? w_fail_dst : TRAIN_TX;
            TRAIN_RX:   w_next = w_rx_match ? UP : w_timeout ? w_fail_dst : TRAIN_RX;
            UP:         w_next = w_aligned ? UP : RST_LVDS;
            default:    w_next = FAIL;
        endcase
    end

    always_comb begin
        req0_ready = w_up & RDY_enq_tx & req0_valid & (~req1_valid | ~r_prio);
        req1_ready = w_up & RDY_enq_tx & req1_valid & (~req0_valid | r_prio);
        EN_enq_tx  = (r_state == TRAIN_TX) ? RDY_enq_tx : (req0_ready | req1_ready);
        enq_tx     = (r_state == TRAIN_TX) ? TRAIN_WORD :
                     req1_ready ? req1_data : req0_ready ? req0_data : '0;
        EN_deq_rx  = (r_state == TRAIN_RX) ? RDY_deq_rx : (w_up & RDY_deq_rx & rx_ready);
        rx_valid   = w_up & RDY_deq_rx;
        rx_data    = w_up ? deq_rx : '0;
    end

    assign lvds_reset_n = r_lvds_reset_n;
    assign link_up      = r_link_up;
    assign link_fail    = r_link_fail;
    assign retry_cnt    = r_retry_cnt;
endmodule

// File: tb/tb_lvds_link_ctrl.sv
// tb_lvds_link_ctrl: bring-up, retry/fail, round-robin and receive-path checks
// with scoreboard queues for transmit grants and consumed receive words.
module tb_lvds_link_ctrl;
    localparam logic [31:0] TRAIN_WORD = 32'hA5C3_5A3C;

    typedef struct {
        logic [31:0] d;
        logic        id;
    } tx_exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        tx_align_done, rx_align_done, lvds_reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data, enq_tx, deq_rx, rx_data;
    logic        EN_enq_tx, RDY_enq_tx, RDY_deq_rx, EN_deq_rx, rx_valid, rx_ready;
    logic        link_up, link_fail;
    logic [1:0]  retry_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        m_prio = 1'b0;
    tx_exp_t     tx_q[$];
    logic [31:0] rx_q[$];

    lvds_link_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .tx_align_done(tx_align_done), .rx_align_done(rx_align_done),
        .lvds_reset_n(lvds_reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .enq_tx(enq_tx), .EN_enq_tx(EN_enq_tx), .RDY_enq_tx(RDY_enq_tx),
        .deq_rx(deq_rx), .RDY_deq_rx(RDY_deq_rx), .EN_deq_rx(EN_deq_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic train_tx_phase();
        int n = 0;
        tx_align_done = 1'b1;
        rx_align_done = 1'b1;
        RDY_enq_tx    = 1'b1;
        RDY_deq_rx    = 1'b0;
        while (!EN_enq_tx && n < 200) begin
            tick();
            n++;
        end
        check("train_tx_en", EN_enq_tx, 1);
        check("train_word", enq_tx, TRAIN_WORD);
        check("train_link_down", link_up, 0);
        tick();
        check("train_rx_no_enq", EN_enq_tx, 0);
    endtask

    task automatic train_rx_phase(input bit garbage);
        repeat (4) tick();
        if (garbage) begin
            deq_rx = 32'h0000_0001;
            RDY_deq_rx = 1'b1;
            #1;
            check("garbage_consumed", EN_deq_rx, 1);
            check("rx_valid_training", rx_valid, 0);
            tick();
            check("garbage_dropped", link_up, 0);
        end
        deq_rx = TRAIN_WORD;
        RDY_deq_rx = 1'b1;
        #1;
        check("train_rx_en", EN_deq_rx, 1);
        tick();
        RDY_deq_rx = 1'b0;
        check("link_up", link_up, 1);
        check("retry_up", retry_cnt, 0);
        check("lvds_up", lvds_reset_n, 1);
    endtask

    task automatic tx_cycle(input logic v0, input logic v1, input logic rdy);
        tx_exp_t e;
        logic    g;
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = $urandom;
        req1_data  = $urandom;
        RDY_enq_tx = rdy;
        if (rdy && (v0 || v1)) begin
            g = (v0 && v1) ? m_prio : v1;
            tx_q.push_back('{g ? req1_data : req0_data, g});
            m_prio = ~g;
        end
        #1;
        if (!rdy) check("no_ready", {req0_ready, req1_ready}, 0);
        if (EN_enq_tx) begin
            if (tx_q.size() == 0) check("tx_spurious", 1, 0);
            else begin
                e = tx_q.pop_front();
                check("tx_data", enq_tx, e.d);
                check("tx_grant", req1_ready, e.id);
            end
        end
        tick();
    endtask

    task automatic rx_cycle(input logic rdy, input logic rdy_c);
        deq_rx     = $urandom;
        RDY_deq_rx = rdy;
        rx_ready   = rdy_c;
        if (rdy && rdy_c) rx_q.push_back(deq_rx);
        #1;
        check("rx_valid", rx_valid, rdy);
        if (EN_deq_rx) begin
            if (rx_q.size() == 0) check("rx_spurious", 1, 0);
            else check("rx_data", rx_data, rx_q.pop_front());
        end
        tick();
    endtask

    initial begin
        RST_N = 1'b0;
        tx_align_done = 1'b0;
        rx_align_done = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 32'h1111_1111;
        req1_data = 32'h2222_2222;
        RDY_enq_tx = 1'b1;
        deq_rx = 32'hDEAD_BEEF;
        RDY_deq_rx = 1'b1;
        rx_ready = 1'b1;
        repeat (2) tick();
        check("rst_lvds_reset_n", lvds_reset_n, 0);
        check("rst_link", {link_up, link_fail, retry_cnt}, 0);
        check("rst_handshakes", {req0_ready, req1_ready, EN_enq_tx, EN_deq_rx, rx_valid}, 0);
        check("rst_enq_tx", enq_tx, 0);
        check("rst_rx_data", rx_data, 0);

        // Clean bring-up: aligns rise 20 cycles after reset
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        RDY_deq_rx = 1'b0;
        rx_ready = 1'b0;
        RST_N = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check("hold_no_enq", {EN_enq_tx, enq_tx}, 0);
            if (i == 15) check("hold_lvds_low", lvds_reset_n, 0);
            if (i == 16) check("hold_lvds_high", lvds_reset_n, 1);
        end
        train_tx_phase();
        train_rx_phase(1'b0);

        // Round robin: continuous, then blocked, then random
        for (int i = 0; i < 8; i++) tx_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tx_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) tx_cycle(1'($urandom), 1'($urandom), 1'($urandom));
        check("tx_sb_empty", tx_q.size(), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        for (int i = 0; i < 40; i++) rx_cycle(1'($urandom), 1'($urandom));
        check("rx_sb_empty", rx_q.size(), 0);
        RDY_deq_rx = 1'b0;
        rx_ready = 1'b0;

        // Link drop while UP
        req0_valid = 1'b1;
        RDY_enq_tx = 1'b1;
        rx_align_done = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 2) check("drop_still_up", link_up, 1);
            if (i == 3) begin
                check("drop_link_down", link_up, 0);
                check("drop_lvds_low", lvds_reset_n, 0);
                check("drop_no_xfer", EN_enq_tx, 0);
                check("drop_retry", retry_cnt, 0);
            end
            if (i == 18) check("drop_hold_low", lvds_reset_n, 0);
            if (i == 19) check("drop_hold_done", lvds_reset_n, 1);
        end
        req0_valid = 1'b0;
        train_tx_phase();
        train_rx_phase(1'b0);

        // Async reset in TRAIN_RX, then bring-up with garbage ahead of the echo
        rx_align_done = 1'b0;
        repeat (19) tick();
        train_tx_phase();
        deq_rx = 32'h0BAD_0BAD;
        RDY_deq_rx = 1'b1;
        #1;
        check("arst_in_train_rx", EN_deq_rx, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_en_deq", EN_deq_rx, 0);
        check("arst_lvds", lvds_reset_n, 0);
        check("arst_status", {link_up, link_fail, retry_cnt}, 0);
        tick();
        RDY_deq_rx = 1'b0;
        RST_N = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("arst_hold_low", lvds_reset_n, 0);
            if (i == 16) check("arst_hold_high", lvds_reset_n, 1);
        end
        train_tx_phase();
        train_rx_phase(1'b1);

        // Alignment never arrives: three retries then sticky FAIL
        tx_align_done = 1'b0;
        rx_align_done = 1'b0;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 1; i <= 16648; i++) begin
            tick();
            if (i == 4111) check("retry0", retry_cnt, 0);
            if (i == 4112) check("retry1", {lvds_reset_n, retry_cnt}, {1'b0, 2'd1});
            if (i == 8223) check("retry1_hold", retry_cnt, 1);
            if (i == 8224) check("retry2", retry_cnt, 2);
            if (i == 12336) check("retry3", retry_cnt, 3);
            if (i == 16447) check("fail_not_yet", link_fail, 0);
            if (i == 16448) check("fail", {link_fail, lvds_reset_n, retry_cnt}, {1'b1, 1'b1, 2'd3});
            if (i == 16500) begin
                tx_align_done = 1'b1;
                rx_align_done = 1'b1;
            end
        end
        check("fail_sticky", {link_fail, link_up, lvds_reset_n}, 3'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lvds_link_ctrl.md
# lvds_link_ctrl

Link controller for one FPGA-to-FPGA LVDS lane pair. It brings the link up in four steps: it resets the LVDS serdes, waits for TX/RX alignment, then sends a training word and requires it to come back. After bring-up it arbitrates two 32-bit requesters onto the single LVDS transmit enqueue port, round-robin, and gates the receive dequeue port to the consumer. It sits between the application cores and the LVDS serdes wrapper in each FPGA's top level.

## Interface
Parameters:
- `DATA_W`, 32: word width on every data port.
- `RST_HOLD`, 16: cycles `lvds_reset_n` is held low per bring-up attempt.
- `TIMEOUT`, 4096: cycle budget for each of the WAIT_ALIGN and TRAIN phases.
- `MAX_RETRY`, 3: failed attempts before entering FAIL.
- `TRAIN_WORD`, 32'hA5C3_5A3C: training pattern.

Ports:
- `CLK` in 1: single clock, the LVDS tx_inclock domain.
- `RST_N` in 1: asynchronous, active-low reset.
- `tx_align_done` in 1: from the serdes, asynchronous to `CLK`.
- `rx_align_done` in 1: from the serdes, asynchronous to `CLK`.
- `lvds_reset_n` out 1: reset to the serdes, active-low.
- `req0_valid` in 1, `req0_data` in DATA_W, `req0_ready` out 1: requester 0.
- `req1_valid` in 1, `req1_data` in DATA_W, `req1_ready` out 1: requester 1.
- `enq_tx` out DATA_W, `EN_enq_tx` out 1, `RDY_enq_tx` in 1: serdes transmit.
- `deq_rx` in DATA_W, `RDY_deq_rx` in 1, `EN_deq_rx` out 1: serdes receive.
- `rx_data` out DATA_W, `rx_valid` out 1, `rx_ready` in 1: consumer.
- `link_up` out 1, `link_fail` out 1, `retry_cnt` out 2: status.

## Operation
- `tx_align_done` and `rx_align_done` each pass through a 2-flop synchronizer. `aligned` is the AND of the two synced signals.
- State machine states are RST_LVDS, WAIT_ALIGN, TRAIN_TX, TRAIN_RX, UP and FAIL. Reset enters RST_LVDS with `retry_cnt`=0.
- RST_LVDS:
  - `lvds_reset_n`=0 for RST_HOLD cycles, then go to WAIT_ALIGN.
  - The timeout counter clears on entry to every state.
- WAIT_ALIGN: go to TRAIN_TX when `aligned`=1. If TIMEOUT cycles pass without it, fail the attempt.
- TRAIN_TX:
  - Drive `enq_tx`=TRAIN_WORD and `EN_enq_tx`=`RDY_enq_tx`.
  - The first cycle that enqueue fires, go to TRAIN_RX.
  - Timeout: fail the attempt.
- TRAIN_RX:
  - `EN_deq_rx`=`RDY_deq_rx`; every received word is consumed internally.
  - A word equal to TRAIN_WORD goes to UP.
  - Any other word is discarded and the state stays in TRAIN_RX.
  - Timeout: fail the attempt.
- Failed attempt:
  - If `retry_cnt` < MAX_RETRY, increment `retry_cnt` and return to RST_LVDS.
  - Otherwise go to FAIL.
- UP:
  - `link_up`=1 and `retry_cnt` clears.
  - If `aligned` falls, go to RST_LVDS. This is not counted as a retry.
- FAIL: `link_fail`=1 and `lvds_reset_n`=1. The state is sticky until `RST_N`.
- Arbitration, active only in UP:
  - `req0_ready` = UP & `RDY_enq_tx` & `req0_valid` & (!`req1_valid` | `prio`==0).
  - `req1_ready` is symmetric, with `prio`==1.
  - `EN_enq_tx` = `req0_ready` | `req1_ready`, and `enq_tx` muxes the granted requester's data.
  - After a transfer by requester i, `prio` becomes !i. A requester valid alone is granted regardless of `prio`.
- Receive path in UP: `rx_data`=`deq_rx`, `rx_valid`=`RDY_deq_rx`, `EN_deq_rx`=`RDY_deq_rx` & `rx_ready`.
- Outside UP:
  - `req*_ready`=0 and `rx_valid`=0.
  - `EN_enq_tx`=0 except in TRAIN_TX; `EN_deq_rx`=0 except in TRAIN_RX.
  - `enq_tx`=0 except in TRAIN_TX.

## Timing
- Reset values: `lvds_reset_n`=0, `link_up`=0, `link_fail`=0, `retry_cnt`=0, `prio`=0, all EN/ready/valid outputs 0, `enq_tx`=0, `rx_data`=0 (because `RDY_deq_rx` is gated outside UP).
- `lvds_reset_n`, `link_up`, `link_fail` and `retry_cnt` are registered and follow the state register with no extra delay.
- Arbiter outputs and receive-path outputs are combinational from inputs and state, so transfers complete in the same cycle with zero latency.
- `aligned` lags the raw inputs by 2 cycles. Deassertion in UP drops `link_up` 1 cycle after `aligned` falls, and no transfer occurs in that next cycle.
- Timeout fires when the counter reaches TIMEOUT-1, so the state changes on the TIMEOUT-th cycle in the state.
- A training match and a timeout in the same cycle: the match wins and the state goes to UP.
- Asserting `RST_N` mid-operation returns immediately to RST_LVDS and clears all counters.

## Test plan
- Clean bring-up:
  - Stimulus: align inputs rise 20 cycles after reset; loopback echoes TRAIN_WORD 5 cycles after the TX enqueue.
  - Required: `lvds_reset_n` high at cycle 16, `link_up`=1 with `retry_cnt`=0.
- Garbage before echo:
  - Stimulus: RX returns 32'h0000_0001 then TRAIN_WORD.
  - Required: the first word is consumed and dropped, the second brings the link to UP.
- Timeouts:
  - Stimulus: alignment never asserts.
  - Required: `retry_cnt` steps 1, 2, 3, then FAIL. `link_fail`=1 after 4×(16+4096) cycles plus transitions, and stays sticky.
- Round robin:
  - Stimulus: both requesters valid continuously with `RDY_enq_tx`=1.
  - Required: grants alternate 0,1,0,1 and `enq_tx` matches each granted requester's data.
  - Stimulus: with `RDY_enq_tx`=0.
  - Required: no ready is asserted.
- Link drop:
  - Stimulus: `rx_align_done` falls while in UP.
  - Required: `link_up`=0 3 cycles later, `lvds_reset_n`=0 for 16 cycles, `retry_cnt` unchanged, a full re-train follows.
- Async reset:
  - Stimulus: `RST_N` pulsed low during TRAIN_RX.
  - Required: all outputs return to their reset values immediately, then bring-up restarts.
